// File: rtl/pintar_pkg.sv
// Shared menu-state codes and frame helpers for the matrix painter.
// The game-logic FSM and the scan painter agree on these encodings.
package pintar_pkg;

    localparam int ESTADO_W  = 3;
    localparam int MAX_BUS_W = 4096;
    localparam int MAX_COLS  = 64;

    typedef enum logic [ESTADO_W-1:0] {
        Inicio      = 3'b000,
        Seleccion1  = 3'b001,
        Seleccion2  = 3'b010,
        Seleccion3  = 3'b011,
        Seleccion4  = 3'b100,
        GanarJuego  = 3'b101,
        PerderJuego = 3'b110,
        Juego       = 3'b111
    } estado_e;

    // Row r of a row-major packed frame; callers size-cast the result to COLS.
    function automatic logic [MAX_COLS-1:0] get_row(input logic [MAX_BUS_W-1:0] bus,
                                                    input int unsigned r,
                                                    input int unsigned cols);
        return MAX_COLS'(bus >> (r * cols)) & ((MAX_COLS'(1) << cols) - MAX_COLS'(1));
    endfunction

endpackage

// File: rtl/pintar_matriz_scan_if.sv
// Layer inputs and LED-matrix outputs of the scan painter, grouped as one bus.
// Game logic drives through master; the painter attaches as slave.
interface pintar_matriz_scan_if
    import pintar_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int EST_W = ESTADO_W
);
    logic [ROWS*COLS-1:0] PINTAR_RANA_IN;
    logic [ROWS*COLS-1:0] PINTAR_VEHICULOS_IN;
    logic [ROWS*COLS-1:0] PINTAR_MENU_IN;
    logic [EST_W-1:0]     PINTAR_ESTADO_IN;
    logic                 PINTAR_BLINK_EN_IN;
    logic [ROWS-1:0]      PINTAR_ROW_OUT;
    logic [COLS-1:0]      PINTAR_COL_OUT;
    logic                 PINTAR_FRAME_OUT;
    logic                 PINTAR_COLISION_OUT;

    modport master (
        output PINTAR_RANA_IN, PINTAR_VEHICULOS_IN, PINTAR_MENU_IN,
               PINTAR_ESTADO_IN, PINTAR_BLINK_EN_IN,
        input  PINTAR_ROW_OUT, PINTAR_COL_OUT, PINTAR_FRAME_OUT, PINTAR_COLISION_OUT
    );

    modport slave (
        input  PINTAR_RANA_IN, PINTAR_VEHICULOS_IN, PINTAR_MENU_IN,
               PINTAR_ESTADO_IN, PINTAR_BLINK_EN_IN,
        output PINTAR_ROW_OUT, PINTAR_COL_OUT, PINTAR_FRAME_OUT, PINTAR_COLISION_OUT
    );
endinterface

// File: rtl/pintar_scan_timer.sv
// Row-hold and row-index counters for the matrix scan; flags row advance
// and frame wrap. Starts on the last row so the first advance is a wrap.
module pintar_scan_timer #(
    parameter int ROWS     = 8,
    parameter int ROW_HOLD = 1024,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int HW      = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          advance,
    output logic          wrap,
    output logic [RW-1:0] row_idx,
    output logic [RW-1:0] row_nxt
);
    logic [HW-1:0] hold_cnt;

    assign advance = (hold_cnt == HW'(ROW_HOLD - 1));
    assign wrap    = advance && (row_idx == RW'(ROWS - 1));
    assign row_nxt = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            row_idx  <= RW'(ROWS - 1);
        end else if (advance) begin
            hold_cnt <= '0;
            row_idx  <= row_nxt;
        end else begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end
endmodule

// File: rtl/pintar_matriz_scan.sv
// Composes frog, vehicle and menu layers into a double-buffered frame and
// row-scans it to the LED matrix, with frog blinking and frame-synchronous collision.
module pintar_matriz_scan
    import pintar_pkg::get_row;
    import pintar_pkg::MAX_BUS_W;
#(
    parameter int                  ROWS         = 8,
    parameter int                  COLS         = 8,
    parameter int                  ROW_HOLD     = 1024,
    parameter int                  BLINK_FRAMES = 16,
    parameter int                  ESTADO_W     = 3,
    parameter logic [ESTADO_W-1:0] JUEGO        = 3'b111,
    localparam int                 RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int                 BW           = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
    input logic                PINTAR_CLOCK,
    input logic                PINTAR_RESET,
    pintar_matriz_scan_if.slave bus
);
    typedef logic [ROWS-1:0][COLS-1:0] frame_t;

    logic          advance, wrap;
    logic [RW-1:0] row_idx, row_nxt;

    frame_t          rana_f, veh_f, menu_f, composed, shadow;
    logic            juego, frog_vis, hit;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic [ROWS-1:0] row_out;
    logic [COLS-1:0] col_out;
    logic            frame_out, colision;

    pintar_scan_timer #(.ROWS(ROWS), .ROW_HOLD(ROW_HOLD)) u_timer (
        .clk     (PINTAR_CLOCK),
        .rst_n   (PINTAR_RESET),
        .advance (advance),
        .wrap    (wrap),
        .row_idx (row_idx),
        .row_nxt (row_nxt)
    );

    assign juego    = (bus.PINTAR_ESTADO_IN == JUEGO);
    assign frog_vis = !bus.PINTAR_BLINK_EN_IN || blink_phase;

    // Vehicles exist only in the lanes; first and last rows are safe zones.
    // The collision term uses the unmasked frog so a blinked-out frog still dies.
    always_comb begin
        rana_f   = '0;
        veh_f    = '0;
        menu_f   = '0;
        composed = '0;
        hit      = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            rana_f[r] = COLS'(get_row(MAX_BUS_W'(bus.PINTAR_RANA_IN), r, COLS));
            menu_f[r] = COLS'(get_row(MAX_BUS_W'(bus.PINTAR_MENU_IN), r, COLS));
            if (r > 0 && r < ROWS - 1)
                veh_f[r] = COLS'(get_row(MAX_BUS_W'(bus.PINTAR_VEHICULOS_IN), r, COLS));
            composed[r] = juego ? ((rana_f[r] & {COLS{frog_vis}}) | veh_f[r]) : menu_f[r];
            hit         = hit | (|(rana_f[r] & veh_f[r]));
        end
    end

    // NOTE: shadow is a flop bank, not a RAM, so it can and does clear on
    // reset; a RAM-backed buffer could not be reset this way.
    always_ff @(posedge PINTAR_CLOCK or negedge PINTAR_RESET) begin
        if (!PINTAR_RESET) begin
            shadow      <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            row_out     <= '0;
            col_out     <= '0;
            frame_out   <= 1'b0;
            colision    <= 1'b0;
        end else begin
            frame_out <= wrap;
            if (wrap) begin
                shadow   <= composed;
                colision <= juego && hit;
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
            // On wrap the fresh composition goes straight out, skipping the stale shadow.
            if (advance) begin
                row_out <= ROWS'(1) << row_nxt;
                col_out <= wrap ? composed[0] : shadow[row_nxt];
            end
        end
    end

    assign bus.PINTAR_ROW_OUT      = row_out;
    assign bus.PINTAR_COL_OUT      = col_out;
    assign bus.PINTAR_FRAME_OUT    = frame_out;
    assign bus.PINTAR_COLISION_OUT = colision;
endmodule

// File: tb/tb_pintar_matriz_scan.sv
// Self-checking bench for pintar_matriz_scan: frame-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pintar_matriz_scan;
    import pintar_pkg::*;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int HOLD = 4;
    localparam int BF   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pintar_matriz_scan_if #(.ROWS(ROWS), .COLS(COLS), .EST_W(3)) bus ();

    pintar_matriz_scan #(
        .ROWS(ROWS), .COLS(COLS), .ROW_HOLD(HOLD), .BLINK_FRAMES(BF),
        .ESTADO_W(3), .JUEGO(3'b111)
    ) dut (
        .PINTAR_CLOCK (clk),
        .PINTAR_RESET (rst_n),
        .bus          (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: clock edge n (counted from reset release) is an
    // advance when n is a multiple of HOLD; advance k shows row (k-1)%ROWS.
    int         n, fcount;
    logic [7:0] mframe[ROWS];
    logic [7:0] e_row, e_col;
    logic       e_frame, e_hit;

    function automatic logic [7:0] model_row(int rr, int f);
        logic [7:0] rana, veh;
        bit vis;
        rana = bus.PINTAR_RANA_IN[rr*COLS +: COLS];
        veh  = bus.PINTAR_VEHICULOS_IN[rr*COLS +: COLS];
        if (bus.PINTAR_ESTADO_IN != 3'b111) return bus.PINTAR_MENU_IN[rr*COLS +: COLS];
        vis = !bus.PINTAR_BLINK_EN_IN || (((f - 1) / BF) % 2 == 0);
        return (vis ? rana : 8'h00) | ((rr >= 1 && rr <= ROWS - 2) ? veh : 8'h00);
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        int r;
        if (!rst_n) begin
            n = 0; fcount = 0;
            e_row = '0; e_col = '0; e_frame = 1'b0; e_hit = 1'b0;
            foreach (mframe[i]) mframe[i] = '0;
        end else begin
            n++;
            e_frame = 1'b0;
            if (n % HOLD == 0) begin
                r = (n / HOLD - 1) % ROWS;
                if (r == 0) begin
                    fcount++;
                    e_hit = 1'b0;
                    for (int rr = 0; rr < ROWS; rr++) begin
                        mframe[rr] = model_row(rr, fcount);
                        if (bus.PINTAR_ESTADO_IN == 3'b111 && rr >= 1 && rr <= ROWS - 2 &&
                            (bus.PINTAR_RANA_IN[rr*COLS +: COLS] & bus.PINTAR_VEHICULOS_IN[rr*COLS +: COLS]) != 0)
                            e_hit = 1'b1;
                    end
                    e_frame = 1'b1;
                end
                e_row = 8'h01 << r;
                e_col = mframe[r];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_row",      bus.PINTAR_ROW_OUT,      e_row);
            check("cmp_col",      bus.PINTAR_COL_OUT,      e_col);
            check("cmp_frame",    bus.PINTAR_FRAME_OUT,    e_frame);
            check("cmp_colision", bus.PINTAR_COLISION_OUT, e_hit);
        end
    end

    task automatic wait_frame();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.PINTAR_FRAME_OUT) break;
        end
        if (i == 200) begin
            checks++; errors++;
            $display("FAIL wait_frame: no frame pulse within 200 cycles");
        end
    endtask

    task automatic wait_row(input int r);
        int i;
        logic [7:0] want;
        want = 8'h01 << r;
        for (i = 0; i < 100; i++) begin
            if (bus.PINTAR_ROW_OUT == want) break;
            @(negedge clk);
        end
        if (i == 100) begin
            checks++; errors++;
            $display("FAIL wait_row: row %0d never active within 100 cycles", r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp8;
        bus.PINTAR_RANA_IN      = '0;
        bus.PINTAR_VEHICULOS_IN = '0;
        bus.PINTAR_MENU_IN      = '0;
        bus.PINTAR_ESTADO_IN    = Inicio;
        bus.PINTAR_BLINK_EN_IN  = 1'b0;

        // Reset state and first-frame timing
        repeat (2) @(negedge clk);
        check("rst_row", bus.PINTAR_ROW_OUT, 0);
        check("rst_col", bus.PINTAR_COL_OUT, 0);
        check("rst_frame", bus.PINTAR_FRAME_OUT, 0);
        check("rst_colision", bus.PINTAR_COLISION_OUT, 0);
        rst_n = 1'b1;
        for (int i = 0; i < HOLD - 1; i++) begin
            @(negedge clk);
            check("t1_blank_row", bus.PINTAR_ROW_OUT, 0);
            check("t1_blank_frame", bus.PINTAR_FRAME_OUT, 0);
        end
        @(negedge clk);
        check("t1_first_row", bus.PINTAR_ROW_OUT, 8'h01);
        check("t1_first_frame", bus.PINTAR_FRAME_OUT, 1);
        for (int k = 1; k <= ROWS; k++) begin
            repeat (HOLD) @(negedge clk);
            exp8 = (k < ROWS) ? (8'h01 << k) : 8'h01;
            check("t1_row_step", bus.PINTAR_ROW_OUT, exp8);
        end

        // Game composition, vehicles masked in safe row 0
        bus.PINTAR_ESTADO_IN = Juego;
        bus.PINTAR_RANA_IN = '0;
        bus.PINTAR_RANA_IN[0 +: 8] = 8'h10;
        bus.PINTAR_VEHICULOS_IN = '0;
        bus.PINTAR_VEHICULOS_IN[0 +: 8]  = 8'hFF;
        bus.PINTAR_VEHICULOS_IN[24 +: 8] = 8'h0F;
        wait_frame();
        check("t2_row0", bus.PINTAR_COL_OUT, 8'h10);
        wait_row(3);
        check("t2_row3", bus.PINTAR_COL_OUT, 8'h0F);
        check("t2_colision", bus.PINTAR_COLISION_OUT, 0);

        // Collision in a lane, none in the safe zone
        bus.PINTAR_RANA_IN = '0;
        bus.PINTAR_RANA_IN[24 +: 8] = 8'h01;
        bus.PINTAR_VEHICULOS_IN[24 +: 8] = 8'h01;
        wait_frame();
        check("t3_hit", bus.PINTAR_COLISION_OUT, 1);
        bus.PINTAR_RANA_IN = '0;
        bus.PINTAR_RANA_IN[0 +: 8] = 8'h01;
        wait_frame();
        check("t3_safe", bus.PINTAR_COLISION_OUT, 0);

        // Menu screen overrides game layers
        bus.PINTAR_ESTADO_IN = GanarJuego;
        bus.PINTAR_MENU_IN = {8{8'hAA}};
        bus.PINTAR_RANA_IN = '1;
        bus.PINTAR_VEHICULOS_IN = '1;
        wait_frame();
        for (int r = 0; r < ROWS; r++) begin
            wait_row(r);
            check("t4_menu_row", bus.PINTAR_COL_OUT, 8'hAA);
            check("t4_colision", bus.PINTAR_COLISION_OUT, 0);
        end

        // Blinking frog from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        bus.PINTAR_ESTADO_IN = Juego;
        bus.PINTAR_BLINK_EN_IN = 1'b1;
        bus.PINTAR_RANA_IN = '0;
        bus.PINTAR_RANA_IN[16 +: 8] = 8'h20;
        bus.PINTAR_VEHICULOS_IN = '0;
        rst_n = 1'b1;
        for (int f = 1; f <= 8; f++) begin
            wait_frame();
            wait_row(2);
            exp8 = (f == 3 || f == 4) ? 8'h00 : 8'h20;
            check("t5_blink", bus.PINTAR_COL_OUT, exp8);
            if (f == 6) bus.PINTAR_BLINK_EN_IN = 1'b0;
        end

        // Mid-frame state change must not tear the displayed frame
        bus.PINTAR_RANA_IN = '0;
        bus.PINTAR_RANA_IN[56 +: 8] = 8'h80;
        bus.PINTAR_VEHICULOS_IN = '0;
        for (int r = 1; r <= 6; r++) bus.PINTAR_VEHICULOS_IN[r*8 +: 8] = 8'h0F;
        bus.PINTAR_MENU_IN = {8{8'h55}};
        wait_frame();
        wait_row(4);
        bus.PINTAR_ESTADO_IN = PerderJuego;
        wait_row(5);
        check("t6_row5_game", bus.PINTAR_COL_OUT, 8'h0F);
        wait_row(6);
        check("t6_row6_game", bus.PINTAR_COL_OUT, 8'h0F);
        wait_row(7);
        check("t6_row7_game", bus.PINTAR_COL_OUT, 8'h80);
        wait_frame();
        check("t6_menu_row0", bus.PINTAR_COL_OUT, 8'h55);
        wait_row(3);
        check("t6_menu_row3", bus.PINTAR_COL_OUT, 8'h55);

        // Asynchronous reset mid-row
        bus.PINTAR_ESTADO_IN = Juego;
        bus.PINTAR_RANA_IN[40 +: 8] = 8'h01;
        wait_frame();
        check("t6_hit", bus.PINTAR_COLISION_OUT, 1);
        wait_row(2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_row", bus.PINTAR_ROW_OUT, 0);
        check("t6_async_col", bus.PINTAR_COL_OUT, 0);
        check("t6_async_colision", bus.PINTAR_COLISION_OUT, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
